// File: rtl/pll_reconfig_ctrl.sv
// PLL divider reprogramming sequencer: reset pulse, lock wait, stability qualification, bounded retry.
// Optional macro PLL_CTRL_AUTO_RELOCK_EN restarts the current profile after a sustained loss of lock.
module pll_reconfig_ctrl #(
  parameter int          RST_CYCLES    = 16,
  parameter int          LOCK_TIMEOUT  = 4096,
  parameter int          STABLE_CYCLES = 64,
  parameter int          MAX_RETRY     = 3,
  parameter logic [17:0] PROF0         = 18'h0,
  parameter logic [17:0] PROF1         = 18'h0,
  parameter logic [17:0] PROF2         = 18'h0,
  parameter logic [17:0] PROF3         = 18'h0
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] prof_sel,
  input  logic       lock,
  output logic       pll_reset,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [5:0] odsel,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] cur_prof
);
  // state     | meaning
  // HOLD_RST  | pll_reset high, divider codes already applied and held
  // WAIT_LOCK | waiting for lock_s, timeout counter running
  // STABLE    | lock_s high, qualifying for STABLE_CYCLES consecutive cycles
  // LOCKED    | profile good, accepting requests
  // ERROR     | all attempts failed, accepting requests
  typedef enum logic [2:0] {HOLD_RST, WAIT_LOCK, STABLE, LOCKED, ERROR} state_t;

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int AW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [RW-1:0] RST_MAX  = RW'(RST_CYCLES);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STB_MAX  = SW'(STABLE_CYCLES);
  localparam logic [AW-1:0] AT_MAX   = AW'(MAX_RETRY);

  state_t        state, state_nxt;
  logic          lock_m, lock_s;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] to_cnt;
  logic [SW-1:0] stb_cnt;
  logic [AW-1:0] attempt;
  logic [17:0]   codes, sel_code;
  logic          accept, fail, relock;

`ifdef PLL_CTRL_AUTO_RELOCK_EN
  logic [1:0] lol_cnt;

  // consecutive lock_s=0 cycles while LOCKED
  always_ff @(posedge clkin) begin
    if (reset || state != LOCKED || lock_s) lol_cnt <= 2'd0;
    else if (lol_cnt != 2'd3)               lol_cnt <= lol_cnt + 2'd1;
  end
`endif

  always_comb begin
    sel_code = PROF0;
    case (prof_sel)
      2'd1:    sel_code = PROF1;
      2'd2:    sel_code = PROF2;
      2'd3:    sel_code = PROF3;
      default: sel_code = PROF0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fail      = 1'b0;
    relock    = 1'b0;
    case (state)
      HOLD_RST:  if (rst_cnt == RST_LAST) state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s)                 state_nxt = STABLE;
        else if (to_cnt == TO_LAST) fail = 1'b1;
      end
      STABLE: begin
        if (!lock_s)                 state_nxt = WAIT_LOCK;
        else if (stb_cnt == STB_LAST) state_nxt = LOCKED;
      end
      LOCKED: begin
        if (req) accept = 1'b1;
`ifdef PLL_CTRL_AUTO_RELOCK_EN
        else if (!lock_s && lol_cnt == 2'd3) relock = 1'b1;
`else
        // loss of lock is ignored here until the next request
`endif
      end
      ERROR:   if (req) accept = 1'b1;
      default: state_nxt = HOLD_RST;
    endcase
    if (fail) state_nxt = (attempt < AT_MAX) ? HOLD_RST : ERROR;
    if (accept || relock) state_nxt = HOLD_RST;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state    <= HOLD_RST;
      lock_m   <= 1'b0;
      lock_s   <= 1'b0;
      rst_cnt  <= '0;
      to_cnt   <= '0;
      stb_cnt  <= '0;
      attempt  <= AW'(1);
      codes    <= PROF0;
      cur_prof <= 2'd0;
      done     <= 1'b0;
    end else begin
      lock_m <= lock;
      lock_s <= lock_m;
      state  <= state_nxt;
      done   <= (state_nxt == LOCKED) && (state != LOCKED);

      if (accept) begin
        codes    <= sel_code;
        cur_prof <= prof_sel;
        attempt  <= AW'(1);
      end else if (relock) begin
        attempt <= AW'(1);
      end else if (fail && attempt < AT_MAX) begin
        attempt <= attempt + AW'(1);
      end

      if (state == HOLD_RST && state_nxt == HOLD_RST) begin
        if (rst_cnt != RST_MAX) rst_cnt <= rst_cnt + RW'(1);
      end else begin
        rst_cnt <= '0;
      end

      // timeout spans the whole attempt, including returns from STABLE
      if (state_nxt == HOLD_RST)                                 to_cnt <= '0;
      else if (state == WAIT_LOCK && !lock_s && to_cnt != TO_MAX) to_cnt <= to_cnt + TW'(1);

      if (state == STABLE && state_nxt == STABLE) begin
        if (stb_cnt != STB_MAX) stb_cnt <= stb_cnt + SW'(1);
      end else begin
        stb_cnt <= '0;
      end
    end
  end

  assign pll_reset = (state == HOLD_RST);
  assign busy      = (state != LOCKED) && (state != ERROR);
  assign err       = (state == ERROR);
  assign idsel     = codes[17:12];
  assign fbdsel    = codes[11:6];
  assign odsel     = codes[5:0];

endmodule
